pc_sequencer: RTL

Registered program-counter sequencer with parametrised address width, signed branch displacement and a built-in return stack of configurable depth. It generalises the combinational next-PC selector into the stateful front of the fetch path. It adds CALL/RET nesting, vectored interrupt entry with flag save, RETI with flag restore, stall, and sticky stack-fault reporting. It sits between the instruction decoder (operation, offset, jump target) and the instruction memory address port.

---
 rtl/pc_pkg.sv | 33 +++
 rtl/pc_stack.sv | 49 ++++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: operation codes and return-stack entry layout.
package pc_pkg;

    typedef enum logic [3:0] {
        PC_INC  = 4'b0000,
        PC_HOLD = 4'b0001,
        PC_EI   = 4'b0010,
        PC_DI   = 4'b0011,
        PC_BZ   = 4'b0100,
        PC_BNZ  = 4'b0101,
        PC_BC   = 4'b0110,
        PC_BNC  = 4'b0111,
        PC_JMP  = 4'b1000,
        PC_CALL = 4'b1001,
        PC_RET  = 4'b1010,
        PC_RETI = 4'b1011,
        PC_BRA  = 4'b1100
    } pcop_e;

    // Stack entry packs {addr, zero, carry}; flags occupy the two LSBs at any address width.
    function automatic int entry_w(input int aw);
        return aw + 2;
    endfunction

    localparam int AW_DEF = 12;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic              zero;
        logic              carry;
    } stk_entry_t;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO with a registered top-of-stack copy so a pop can use it in the same cycle.
module pc_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               tos_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] cnt;
    logic [W-1:0]  tos_q;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full_o  = (cnt == DW'(DEPTH));
    assign empty_o = (cnt == '0);
    assign depth_o = cnt;
    assign tos_o   = tos_q;
    assign wr_idx  = IW'(cnt);
    assign rd_idx  = IW'(cnt - DW'(2));

    // On pop the entry below the current top becomes the new cached top.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt   <= '0;
            tos_q <= '0;
        end else if (push_i && !full_o) begin
            mem[wr_idx] <= din_i;
            tos_q       <= din_i;
            cnt         <= cnt + DW'(1);
        end else if (pop_i && !empty_o) begin
            cnt <= cnt - DW'(1);
            if (cnt != DW'(1))
                tos_q <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered next-PC sequencer: branches, CALL/RET nesting, vectored interrupt entry and RETI flag restore.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int             AW        = 12,
    parameter int             OW        = 8,
    parameter int             DEPTH     = 8,
    parameter logic [AW-1:0]  RESET_VEC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       step_i,
    input  logic [3:0]                 pcoper_i,
    input  logic                       zero_i,
    input  logic                       carry_i,
    input  logic [OW-1:0]              offset_i,
    input  logic [AW-1:0]              jump_i,
    input  logic                       irq_i,
    input  logic [AW-1:0]              int_i,
    output logic [AW-1:0]              pc_o,
    output logic                       ie_o,
    output logic                       int_ack_o,
    output logic                       flags_valid_o,
    output logic                       zero_o,
    output logic                       carry_o,
    output logic [$clog2(DEPTH+1)-1:0] stk_depth_o,
    output logic                       stk_ovf_o,
    output logic                       stk_unf_o,
    output logic                       illegal_o
);

    localparam int EW = entry_w(AW);

    logic [AW-1:0] pc_q, pc_d, pc_inc, pc_br, off_x;
    logic          ie_q, ie_d;
    logic          ack_q, ack_d, fv_q, fv_d, ill_q, ill_d;
    logic          z_q, z_d, c_q, c_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push, pop, full, empty, taken;
    logic [EW-1:0] push_data, tos;

    assign off_x  = {{(AW-OW){offset_i[OW-1]}}, offset_i};
    assign pc_inc = pc_q + AW'(1);
    assign pc_br  = pc_inc + off_x;

    always_comb begin
        unique case (pcoper_i[1:0])
            2'b00:   taken = zero_i;
            2'b01:   taken = !zero_i;
            2'b10:   taken = carry_i;
            default: taken = !carry_i;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        ie_d      = ie_q;
        ack_d     = 1'b0;
        fv_d      = 1'b0;
        ill_d     = 1'b0;
        z_d       = z_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = {pc_inc, zero_i, carry_i};
        if (step_i) begin
            // Interrupt preempts the presented op; the preempted PC itself is saved for re-fetch.
            if (irq_i && ie_q) begin
                push      = 1'b1;
                push_data = {pc_q, zero_i, carry_i};
                pc_d      = int_i;
                ie_d      = 1'b0;
                ack_d     = 1'b1;
            end else begin
                case (pcoper_i)
                    PC_INC:  pc_d = pc_inc;
                    PC_HOLD: pc_d = pc_q;
                    PC_EI: begin
                        ie_d = 1'b1;
                        pc_d = pc_inc;
                    end
                    PC_DI: begin
                        ie_d = 1'b0;
                        pc_d = pc_inc;
                    end
                    PC_BZ, PC_BNZ, PC_BC, PC_BNC: pc_d = taken ? pc_br : pc_inc;
                    PC_JMP:  pc_d = jump_i;
                    PC_CALL: begin
                        push = 1'b1;
                        pc_d = jump_i;
                    end
                    PC_RET, PC_RETI: begin
                        pop = 1'b1;
                        if (empty) begin
                            pc_d  = RESET_VEC;
                            unf_d = 1'b1;
                        end else begin
                            pc_d = tos[EW-1:2];
                        end
                        if (pcoper_i == PC_RETI) begin
                            ie_d = 1'b1;
                            fv_d = 1'b1;
                            z_d  = !empty && tos[1];
                            c_d  = !empty && tos[0];
                        end
                    end
                    PC_BRA:  pc_d = pc_br;
                    default: begin
                        pc_d  = pc_inc;
                        ill_d = 1'b1;
                    end
                endcase
            end
            if (push && full)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= RESET_VEC;
            ie_q  <= 1'b0;
            ack_q <= 1'b0;
            fv_q  <= 1'b0;
            ill_q <= 1'b0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ie_q  <= ie_d;
            ack_q <= ack_d;
            fv_q  <= fv_d;
            ill_q <= ill_d;
            z_q   <= z_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_stack #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .tos_o   (tos),
        .full_o  (full),
        .empty_o (empty),
        .depth_o (stk_depth_o)
    );

    assign pc_o          = pc_q;
    assign ie_o          = ie_q;
    assign int_ack_o     = ack_q;
    assign flags_valid_o = fv_q;
    assign zero_o        = z_q;
    assign carry_o       = c_q;
    assign stk_ovf_o     = ovf_q;
    assign stk_unf_o     = unf_q;
    assign illegal_o     = ill_q;

endmodule
